// File: rtl/can_pkg.sv
// Shared types and constants for the CAN bit destuffer.
// Holds the FSM state encoding, the run-counter opcodes and the bus levels.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    STUFF_EXP
  } state_t;

  typedef enum logic [1:0] {
    RUN_HOLD,
    RUN_CLEAR,
    RUN_START,
    RUN_ADVANCE
  } run_op_t;

  localparam int   CAN_STUFF_LEN = 5;
  localparam logic REC           = 1'b1;

endpackage

// File: rtl/can_bit_destuffer_if.sv
// Sample-point side and decoder side signals of the CAN bit destuffer.
// STUFF_CNT exists only when CAN_DESTUFF_STATS_EN is defined.
interface can_bit_destuffer_if #(
  parameter int CNT_W = 3
);

  logic             SP;
  logic             RX;
  logic             F_STF;
  logic             BIT_OUT;
  logic             BIT_VALID;
  logic             STUFF_DROP;
  logic [CNT_W-1:0] RUN_LEN;
`ifdef CAN_DESTUFF_STATS_EN
  logic [15:0]      STUFF_CNT;

  modport master (
    output SP, RX, F_STF,
    input  BIT_OUT, BIT_VALID, STUFF_DROP, RUN_LEN, STUFF_CNT
  );

  modport slave (
    input  SP, RX, F_STF,
    output BIT_OUT, BIT_VALID, STUFF_DROP, RUN_LEN, STUFF_CNT
  );
`else
  modport master (
    output SP, RX, F_STF,
    input  BIT_OUT, BIT_VALID, STUFF_DROP, RUN_LEN
  );

  modport slave (
    input  SP, RX, F_STF,
    output BIT_OUT, BIT_VALID, STUFF_DROP, RUN_LEN
  );
`endif

endinterface

// File: rtl/can_run_counter.sv
// Run-length counter for the destuffer: tracks the last bus bit and how many
// equal bits have been seen in a row, and flags when the run reaches STUFF_LEN.
module can_run_counter
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CNT_W     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  run_op_t          op,
  input  logic             bit_in,
  output logic [CNT_W-1:0] run_len,
  output logic             hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             last_bit;
  logic [CNT_W-1:0] next_len;

  // The count saturates at LIMIT so it can never wrap, even if misused.
  always_comb begin
    next_len = run_len;
    case (op)
      RUN_CLEAR:   next_len = '0;
      RUN_START:   next_len = ONE;
      RUN_ADVANCE: begin
        if (bit_in == last_bit) begin
          next_len = (run_len == LIMIT) ? LIMIT : run_len + ONE;
        end else begin
          next_len = ONE;
        end
      end
      default:     next_len = run_len;
    endcase
  end

  assign hit = (op == RUN_ADVANCE) && (next_len == LIMIT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_len  <= '0;
      last_bit <= REC;
    end else begin
      run_len <= next_len;
      if (op == RUN_START || op == RUN_ADVANCE) begin
        last_bit <= bit_in;
      end
    end
  end

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: removes stuff bits from the sampled RX stream while F_STF is low.
// Define CAN_DESTUFF_STATS_EN to add the saturating STUFF_CNT drop counter.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CNT_W     = 3
) (
  input logic                clock,
  input logic                reset,
  can_bit_destuffer_if.slave bus
);

  state_t           state;
  run_op_t          run_op;
  logic             run_hit;
  logic [CNT_W-1:0] run_len;
  logic             bit_out;
  logic             bit_valid;
  logic             stuff_drop;
  logic             drop_now;

  assign drop_now = bus.SP && (state == STUFF_EXP) && !bus.F_STF;

  // A stuff bit is not data but does seed the next run, hence RUN_START.
  always_comb begin
    run_op = RUN_HOLD;
    if (bus.SP) begin
      case (state)
        IDLE:      run_op = bus.F_STF ? RUN_HOLD  : RUN_START;
        COUNT:     run_op = bus.F_STF ? RUN_CLEAR : RUN_ADVANCE;
        STUFF_EXP: run_op = bus.F_STF ? RUN_CLEAR : RUN_START;
        default:   run_op = RUN_CLEAR;
      endcase
    end
  end

  can_run_counter #(
    .STUFF_LEN (STUFF_LEN),
    .CNT_W     (CNT_W)
  ) u_run_counter (
    .clock   (clock),
    .reset   (reset),
    .op      (run_op),
    .bit_in  (bus.RX),
    .run_len (run_len),
    .hit     (run_hit)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      bit_out    <= REC;
      bit_valid  <= 1'b0;
      stuff_drop <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      stuff_drop <= 1'b0;
      if (bus.SP) begin
        case (state)
          IDLE: begin
            bit_out   <= bus.RX;
            bit_valid <= 1'b1;
            if (!bus.F_STF) state <= COUNT;
          end
          COUNT: begin
            bit_out   <= bus.RX;
            bit_valid <= 1'b1;
            if (bus.F_STF) state <= IDLE;
            else if (run_hit) state <= STUFF_EXP;
          end
          STUFF_EXP: begin
            // Leaving the stuff region at a stuff position delivers the bit.
            if (bus.F_STF) begin
              bit_out   <= bus.RX;
              bit_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              stuff_drop <= 1'b1;
              state      <= COUNT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.BIT_OUT    = bit_out;
  assign bus.BIT_VALID  = bit_valid;
  assign bus.STUFF_DROP = stuff_drop;
  assign bus.RUN_LEN    = run_len;

`ifdef CAN_DESTUFF_STATS_EN
  logic [15:0] stuff_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stuff_cnt <= '0;
    end else if (drop_now && stuff_cnt != 16'hFFFF) begin
      stuff_cnt <= stuff_cnt + 16'd1;
    end
  end

  assign bus.STUFF_CNT = stuff_cnt;
`else
  logic unused_drop;
  assign unused_drop = drop_now;
`endif

endmodule
